// File: rtl/ws2812b_bit_serializer_pkg.sv
// Shared types and default 64 MHz timing for the WS2812B bit serializer.
package ws2812b_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        LATCH = 2'd2
    } state_e;

    localparam int PIXEL_BITS = 24;

    // 64 MHz clock: 1.25 us bit, ~0.40 us / ~0.80 us highs, 300 us latch gap
    localparam int DEF_BIT_CYCLES = 80;
    localparam int DEF_T0H_CYCLES = 26;
    localparam int DEF_T1H_CYCLES = 51;
    localparam int DEF_RES_CYCLES = 19200;

endpackage

// File: rtl/ws2812b_bit_serializer_if.sv
// Pixel handshake between the strip controller (master) and the serializer (slave).
interface ws2812b_bit_serializer_if;
    import ws2812b_pkg::*;

    logic [PIXEL_BITS-1:0] data_in;
    logic                  valid;
    logic                  latch;
    logic                  ready;

    modport master (output data_in, output valid, output latch, input ready);
    modport slave  (input data_in, input valid, input latch, output ready);

endinterface

// File: rtl/ws2812b_bit_serializer.sv
// Serializes one GRB pixel MSB-first as WS2812B pulse-width bits, with an optional latch gap.
module ws2812b_bit_serializer
    import ws2812b_pkg::*;
#(
    parameter int BIT_CYCLES = DEF_BIT_CYCLES,
    parameter int T0H_CYCLES = DEF_T0H_CYCLES,
    parameter int T1H_CYCLES = DEF_T1H_CYCLES,
    parameter int RES_CYCLES = DEF_RES_CYCLES
) (
    input  logic                        clk,
    input  logic                        rst_n,
    ws2812b_bit_serializer_if.slave     pix,
    output logic                        led
);

    localparam int CNT_MAX = (BIT_CYCLES > RES_CYCLES) ? BIT_CYCLES : RES_CYCLES;
    localparam int CW      = $clog2(CNT_MAX);

    localparam logic [CW-1:0] BIT_LAST = CW'(BIT_CYCLES - 1);
    localparam logic [CW-1:0] RES_LAST = CW'(RES_CYCLES - 1);
    localparam logic [CW-1:0] T0H_W    = CW'(T0H_CYCLES);
    localparam logic [CW-1:0] T1H_W    = CW'(T1H_CYCLES);
    localparam logic [4:0]    LAST_BIT = 5'(PIXEL_BITS - 1);

    if (!(T0H_CYCLES > 0 && T0H_CYCLES < T1H_CYCLES && T1H_CYCLES < BIT_CYCLES)) begin : g_bad_timing
        $error("ws2812b_bit_serializer: need 0 < T0H_CYCLES < T1H_CYCLES < BIT_CYCLES");
    end

    state_e                state_q, state_n;
    logic [CW-1:0]         cyc_q, cyc_n;
    logic [4:0]            bit_q, bit_n;
    logic [PIXEL_BITS-1:0] shift_q, shift_n;
    logic                  latch_q, latch_n;
    logic                  ready_q, ready_n;
    logic                  led_q, led_n;

    function automatic logic [CW-1:0] hi_time(input logic one);
        return one ? T1H_W : T0H_W;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cyc_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            latch_q <= 1'b0;
            ready_q <= 1'b1;
            led_q   <= 1'b0;
        end else begin
            state_q <= state_n;
            cyc_q   <= cyc_n;
            bit_q   <= bit_n;
            shift_q <= shift_n;
            latch_q <= latch_n;
            ready_q <= ready_n;
            led_q   <= led_n;
        end
    end

    always_comb begin
        state_n = state_q;
        cyc_n   = cyc_q;
        bit_n   = bit_q;
        shift_n = shift_q;
        latch_n = latch_q;
        ready_n = ready_q;
        led_n   = 1'b0;

        case (state_q)
            IDLE: begin
                if (pix.valid && ready_q) begin
                    shift_n = pix.data_in;
                    latch_n = pix.latch;
                    bit_n   = '0;
                    cyc_n   = '0;
                    ready_n = 1'b0;
                    state_n = SEND;
                end
            end
            SEND: begin
                if (cyc_q == BIT_LAST) begin
                    cyc_n = '0;
                    if (bit_q == LAST_BIT) begin
                        if (latch_q) begin
                            state_n = LATCH;
                        end else begin
                            state_n = IDLE;
                            ready_n = 1'b1;
                        end
                    end else begin
                        shift_n = shift_q << 1;
                        bit_n   = bit_q + 5'd1;
                    end
                end else begin
                    cyc_n = cyc_q + 1'b1;
                end
            end
            LATCH: begin
                if (cyc_q == RES_LAST) begin
                    cyc_n   = '0;
                    state_n = IDLE;
                    ready_n = 1'b1;
                end else begin
                    cyc_n = cyc_q + 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
                ready_n = 1'b1;
            end
        endcase

        // led is registered, so it is derived from the post-edge counter and shift state
        led_n = (state_n == SEND) && (cyc_n < hi_time(shift_n[PIXEL_BITS-1]));
    end

    assign pix.ready = ready_q;
    assign led       = led_q;

endmodule

// File: tb/tb_ws2812b_bit_serializer.sv
// Directed bench: expected pulse widths are queued per pixel and checked by a waveform monitor.
module tb_ws2812b_bit_serializer;
    import ws2812b_pkg::*;

    localparam int BITC = 80;
    localparam int T0H  = 26;
    localparam int T1H  = 51;
    localparam int RES  = 19200;

    typedef struct {
        int high;
        bit last;
    } pulse_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic led;

    ws2812b_bit_serializer_if pix ();

    ws2812b_bit_serializer #(
        .BIT_CYCLES(BITC),
        .T0H_CYCLES(T0H),
        .T1H_CYCLES(T1H),
        .RES_CYCLES(RES)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .pix  (pix),
        .led  (led)
    );

    always #5 clk = ~clk;

    int     checks = 0;
    int     failures = 0;
    pulse_t exp_q[$];
    bit     mon_en = 1'b0;
    logic   prev_led = 1'b0;
    int     hi_len = 0;
    int     lo_len = 0;
    bit     low_pend = 1'b0;
    int     exp_lo = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge and update the waveform monitor there.
    task automatic tick();
        pulse_t e;
        @(negedge clk);
        if (!mon_en) begin
            prev_led = 1'b0;
            hi_len   = 0;
            lo_len   = 0;
            low_pend = 1'b0;
        end else begin
            if (led === 1'b1) begin
                if (prev_led !== 1'b1) begin
                    if (low_pend) chk("bit_low_width", 32'(lo_len), 32'(exp_lo));
                    hi_len = 1;
                end else begin
                    hi_len++;
                end
            end else begin
                if (prev_led === 1'b1) begin
                    chk("pulse_expected", 32'(exp_q.size() != 0), 32'd1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        chk("bit_high_width", 32'(hi_len), 32'(e.high));
                        low_pend = !e.last;
                        exp_lo   = BITC - e.high;
                    end
                    lo_len = 1;
                end else begin
                    lo_len++;
                end
            end
            prev_led = led;
        end
    endtask

    task automatic push_pixel(input logic [23:0] d);
        pulse_t p;
        logic [23:0] v;
        v = d;
        for (int i = 23; i >= 0; i--) begin
            p.high = v[i] ? T1H : T0H;
            p.last = (i == 0);
            exp_q.push_back(p);
        end
    endtask

    // Called at a falling edge where ready is 1; leaves the bench in the first led-high cycle.
    task automatic send(input logic [23:0] d, input logic l);
        push_pixel(d);
        pix.data_in = d;
        pix.latch   = l;
        pix.valid   = 1'b1;
        tick();
        pix.valid   = 1'b0;
        pix.latch   = 1'b0;
        pix.data_in = 24'($urandom);
        chk("accept_ready_low", 32'(pix.ready), 32'd0);
        chk("accept_led_high", 32'(led), 32'd1);
    endtask

    task automatic wait_ready(input int budget, output int cnt);
        cnt = 0;
        while (pix.ready !== 1'b1 && cnt < budget) begin
            tick();
            cnt++;
        end
    endtask

    int cyc;

    initial begin
        pix.data_in = '0;
        pix.valid   = 1'b0;
        pix.latch   = 1'b0;

        // reset state
        repeat (3) tick();
        chk("rst_led", 32'(led), 32'd0);
        chk("rst_ready", 32'(pix.ready), 32'd1);
        rst_n = 1'b1;
        repeat (2) tick();
        chk("idle_led", 32'(led), 32'd0);
        chk("idle_ready", 32'(pix.ready), 32'd1);
        mon_en = 1'b1;
        tick();

        // single pixel, no latch
        send(24'hFF0000, 1'b0);
        wait_ready(3000, cyc);
        chk("ff0000_ready_latency", 32'(cyc), 32'd1920);
        chk("ff0000_last_low", 32'(lo_len), 32'(BITC - T0H + 1));
        repeat (5) tick();
        chk("ff0000_queue_empty", 32'(exp_q.size()), 32'd0);

        // latched pixel with a spurious valid in the middle
        send(24'hA5A5A5, 1'b1);
        repeat (500) tick();
        pix.data_in = 24'h000000;
        pix.valid   = 1'b1;
        repeat (5) tick();
        chk("ignored_valid_ready", 32'(pix.ready), 32'd0);
        pix.valid   = 1'b0;
        wait_ready(30000, cyc);
        chk("a5_ready_latency", 32'(cyc + 505), 32'(24 * BITC + RES));
        chk("a5_latch_low", 32'(lo_len), 32'(BITC - T1H + RES + 1));
        repeat (50) tick();
        chk("a5_no_extra_pixel_ready", 32'(pix.ready), 32'd1);
        chk("a5_queue_empty", 32'(exp_q.size()), 32'd0);

        // back-to-back pixels, valid raised in the cycle ready returns
        send(24'h00FF00, 1'b0);
        wait_ready(3000, cyc);
        chk("00ff00_ready_latency", 32'(cyc), 32'd1920);
        chk("b2b_ready_seen", 32'(pix.ready), 32'd1);
        send(24'h0000FF, 1'b1);
        chk("b2b_gap_low", 32'(lo_len), 32'(BITC - T0H + 1));
        wait_ready(30000, cyc);
        chk("0000ff_ready_latency", 32'(cyc), 32'(24 * BITC + RES));
        chk("0000ff_latch_low", 32'(lo_len), 32'(BITC - T1H + RES + 1));
        tick();
        chk("b2b_queue_empty", 32'(exp_q.size()), 32'd0);

        // asynchronous reset mid-pixel
        send(24'hFFFFFF, 1'b0);
        repeat (100) tick();
        chk("pre_rst_led", 32'(led), 32'd1);
        chk("pre_rst_ready", 32'(pix.ready), 32'd0);
        mon_en = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_led", 32'(led), 32'd0);
        chk("async_rst_ready", 32'(pix.ready), 32'd1);
        exp_q.delete();
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (3) tick();
        chk("post_rst_led", 32'(led), 32'd0);
        chk("post_rst_ready", 32'(pix.ready), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
